// File: rtl/udp_rapid_pkg.sv
// Shared types and constants for the UDP-to-RapidIO payload packer.
package udp_rapid_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PACK = 1'b1
  } state_e;

  localparam int DEF_IN_W  = 32;
  localparam int DEF_OUT_W = 64;
  localparam int RATIO     = DEF_OUT_W / DEF_IN_W;
  localparam int BYTE_W    = 8;
  localparam int KEEP_MAX  = 128;

  function automatic logic [7:0] popcount(input logic [KEEP_MAX-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      c = c + 8'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/udp_rapid_packer.sv
// Packs IN_W-bit UDP payload beats into OUT_W-bit RapidIO words with framing checks.
// Optional byte-count vs. length check is built when UDP_LEN_CHECK_EN is defined.
module udp_rapid_packer
  import udp_rapid_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int LEN_W = 16
) (
  input  logic                 clk_udp,
  input  logic                 reset_udp,
  input  logic [IN_W-1:0]      udp_data_in,
  input  logic [IN_W/8-1:0]    udp_keep_in,
  input  logic                 udp_valid_in,
  input  logic                 udp_first_in,
  input  logic                 udp_last_in,
  input  logic [LEN_W-1:0]     udp_length_in,
  output logic                 udp_ready_out,
  output logic [OUT_W-1:0]     rapid_data_out,
  output logic [OUT_W/8-1:0]   rapid_keep_out,
  output logic                 rapid_valid_out,
  output logic                 rapid_first_out,
  output logic                 rapid_last_out,
  output logic [LEN_W-1:0]     rapid_length_out,
  input  logic                 rapid_ready_in,
  output logic                 proto_err_out,
  output logic                 len_err_out
);

  localparam int LANES = OUT_W / IN_W;
  localparam int IN_K  = IN_W / BYTE_W;
  localparam int OUT_K = OUT_W / BYTE_W;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [OUT_W-1:0]   acc_data_q, acc_data_d;
  logic [OUT_K-1:0]   acc_keep_q, acc_keep_d;
  logic               first_pend_q, first_pend_d;
  logic [LEN_W-1:0]   len_q, len_d;

  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic [OUT_K-1:0]   out_keep_q, out_keep_d;
  logic               out_valid_q, out_valid_d;
  logic               out_first_q, out_first_d;
  logic               out_last_q, out_last_d;
  logic [LEN_W-1:0]   out_len_q, out_len_d;
  logic               perr_q, perr_d;

  logic               accept, start, in_pkt, complete, pkt_first;
  logic [IDX_W-1:0]   lane;
  logic [OUT_W-1:0]   base_data, merged_data;
  logic [OUT_K-1:0]   base_keep, merged_keep;
  logic [LEN_W-1:0]   len_eff;

`ifdef UDP_LEN_CHECK_EN
  logic [LEN_W-1:0]   cnt_q, cnt_d, cnt_new;
  logic               lerr_q, lerr_d;

  function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] a, input logic [7:0] b);
    logic [LEN_W:0] s;
    s = {1'b0, a} + (LEN_W+1)'(b);
    return s[LEN_W] ? '1 : s[LEN_W-1:0];
  endfunction

  assign cnt_new = sat_add(start ? '0 : cnt_q, popcount(KEEP_MAX'(udp_keep_in)));
`endif

  assign udp_ready_out = !out_valid_q || rapid_ready_in;
  assign accept        = udp_valid_in && udp_ready_out;
  assign start         = accept && udp_first_in;
  assign in_pkt        = (state_q == ST_PACK);

  // A first beat always starts a fresh word at lane 0, whatever was pending.
  always_comb begin
    if (start) begin
      base_data = '0;
      base_keep = '0;
      lane      = '0;
      pkt_first = 1'b1;
      len_eff   = udp_length_in;
    end else begin
      base_data = acc_data_q;
      base_keep = acc_keep_q;
      lane      = idx_q;
      pkt_first = first_pend_q;
      len_eff   = len_q;
    end
  end

  always_comb begin
    merged_data = base_data;
    merged_keep = base_keep;
    for (int i = 0; i < LANES; i++) begin
      if (lane == IDX_W'(i)) begin
        merged_data[OUT_W-1-i*IN_W -: IN_W] = udp_data_in;
        merged_keep[OUT_K-1-i*IN_K -: IN_K] = udp_keep_in;
      end
    end
  end

  assign complete = (lane == IDX_LAST) || udp_last_in;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_data_d   = acc_data_q;
    acc_keep_d   = acc_keep_q;
    first_pend_d = first_pend_q;
    len_d        = len_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_valid_d  = out_valid_q;
    out_first_d  = out_first_q;
    out_last_d   = out_last_q;
    out_len_d    = out_len_q;
    perr_d       = 1'b0;
`ifdef UDP_LEN_CHECK_EN
    cnt_d        = cnt_q;
    lerr_d       = lerr_q;
`endif

    if (out_valid_q && rapid_ready_in) begin
      out_valid_d = 1'b0;
      out_first_d = 1'b0;
      out_last_d  = 1'b0;
`ifdef UDP_LEN_CHECK_EN
      lerr_d      = 1'b0;
`endif
    end

    if (accept) begin
      if (!start && !in_pkt) begin
        perr_d = 1'b1;
      end else begin
        perr_d = start && in_pkt;
        len_d  = len_eff;
`ifdef UDP_LEN_CHECK_EN
        cnt_d  = cnt_new;
`endif
        if (complete) begin
          out_valid_d  = 1'b1;
          out_data_d   = merged_data;
          out_keep_d   = merged_keep;
          out_first_d  = pkt_first;
          out_last_d   = udp_last_in;
          out_len_d    = len_eff;
`ifdef UDP_LEN_CHECK_EN
          lerr_d       = udp_last_in && (cnt_new != len_eff);
`endif
          idx_d        = '0;
          acc_data_d   = '0;
          acc_keep_d   = '0;
          first_pend_d = 1'b0;
          state_d      = udp_last_in ? ST_IDLE : ST_PACK;
        end else begin
          acc_data_d   = merged_data;
          acc_keep_d   = merged_keep;
          idx_d        = lane + IDX_W'(1);
          first_pend_d = pkt_first;
          state_d      = ST_PACK;
        end
      end
    end
  end

  always_ff @(posedge clk_udp) begin
    if (reset_udp) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      acc_data_q   <= '0;
      acc_keep_q   <= '0;
      first_pend_q <= 1'b0;
      len_q        <= '0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_valid_q  <= 1'b0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_len_q    <= '0;
      perr_q       <= 1'b0;
`ifdef UDP_LEN_CHECK_EN
      cnt_q        <= '0;
      lerr_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_data_q   <= acc_data_d;
      acc_keep_q   <= acc_keep_d;
      first_pend_q <= first_pend_d;
      len_q        <= len_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_valid_q  <= out_valid_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
      out_len_q    <= out_len_d;
      perr_q       <= perr_d;
`ifdef UDP_LEN_CHECK_EN
      cnt_q        <= cnt_d;
      lerr_q       <= lerr_d;
`endif
    end
  end

  assign rapid_data_out   = out_data_q;
  assign rapid_keep_out   = out_keep_q;
  assign rapid_valid_out  = out_valid_q;
  assign rapid_first_out  = out_first_q;
  assign rapid_last_out   = out_last_q;
  assign rapid_length_out = out_len_q;
  assign proto_err_out    = perr_q;
`ifdef UDP_LEN_CHECK_EN
  assign len_err_out      = lerr_q;
`else
  assign len_err_out      = 1'b0;
`endif

endmodule

// File: tb/tb_udp_rapid_packer.sv
// Directed plus randomized bench for udp_rapid_packer, checked against a packet-level model.
module tb_udp_rapid_packer;

  localparam int IN_W  = 32;
  localparam int OUT_W = 64;
  localparam int LEN_W = 16;
  localparam int R     = OUT_W / IN_W;
  localparam int IN_K  = IN_W / 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [IN_W-1:0]   data = '0;
  logic [IN_K-1:0]   keep = '0;
  logic              valid = 1'b0, first = 1'b0, last = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              ready_out;
  logic [OUT_W-1:0]  rdata;
  logic [OUT_W/8-1:0] rkeep;
  logic              rvalid, rfirst, rlast;
  logic [LEN_W-1:0]  rlen;
  logic              rready = 1'b1;
  logic              perr, lerr;

  always #5 clk = ~clk;

  udp_rapid_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
    .clk_udp(clk), .reset_udp(reset),
    .udp_data_in(data), .udp_keep_in(keep), .udp_valid_in(valid),
    .udp_first_in(first), .udp_last_in(last), .udp_length_in(len),
    .udp_ready_out(ready_out),
    .rapid_data_out(rdata), .rapid_keep_out(rkeep), .rapid_valid_out(rvalid),
    .rapid_first_out(rfirst), .rapid_last_out(rlast), .rapid_length_out(rlen),
    .rapid_ready_in(rready),
    .proto_err_out(perr), .len_err_out(lerr)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    bit          f;
    bit          l;
    logic [15:0] n;
    bit          e;
  } word_t;

  word_t exp_q[$];
  word_t got_q[$];
  int total = 0;
  int bad = 0;
  int perr_seen = 0;
  int perr_exp = 0;
  bit bp_en = 1'b0;
  bit ready_fix = 1'b1;

  // Packet-level reference: beats pending for the current word, packet state.
  logic [31:0] pd[$];
  logic [3:0]  pk[$];
  bit          m_in = 1'b0;
  int          m_words = 0;
  int          m_bytes = 0;
  logic [15:0] m_len = '0;

  function automatic void model_beat(logic [31:0] d, logic [3:0] k, bit f, bit l, logic [15:0] n);
    word_t w;
    if (f) begin
      if (m_in) perr_exp++;
      pd.delete(); pk.delete();
      m_in = 1'b1; m_words = 0; m_bytes = 0; m_len = n;
    end else if (!m_in) begin
      perr_exp++;
      return;
    end
    pd.push_back(d); pk.push_back(k);
    m_bytes = m_bytes + $countones(k);
    if (m_bytes > 65535) m_bytes = 65535;
    if (pd.size() == R || l) begin
      w.d = '0; w.k = '0;
      foreach (pd[i]) begin
        w.d = w.d | (64'(pd[i]) << (IN_W * (R - 1 - i)));
        w.k = w.k | (8'(pk[i]) << (IN_K * (R - 1 - i)));
      end
      w.f = (m_words == 0);
      w.l = l;
      w.n = m_len;
`ifdef UDP_LEN_CHECK_EN
      w.e = l && (m_bytes != int'(m_len));
`else
      w.e = 1'b0;
`endif
      exp_q.push_back(w);
      m_words++;
      pd.delete(); pk.delete();
      if (l) m_in = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    word_t w;
    if (!reset) begin
      if (rvalid && rready) begin
        w.d = rdata; w.k = rkeep; w.f = rfirst; w.l = rlast; w.n = rlen; w.e = lerr;
        got_q.push_back(w);
      end
      if (perr) perr_seen++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_en) rready = ($urandom_range(0, 3) != 0);
    else rready = ready_fix;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input bit f, input bit l,
                           input logic [15:0] n);
    int waitc;
    data = d; keep = k; first = f; last = l; len = n; valid = 1'b1;
    for (waitc = 0; waitc < 200; waitc++) begin
      @(negedge clk);
      if (ready_out) break;
      tick();
    end
    chk("accept_wait", 64'(waitc < 200), 64'(1));
    if (waitc < 200) model_beat(d, k, f, l, n);
    tick();
    valid = 1'b0;
  endtask

  task automatic check_words(input string tag);
    int c = 0;
    word_t e, g;
    while (got_q.size() < exp_q.size() && c < 1000) begin
      tick();
      c++;
    end
    repeat (3) tick();
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({tag, "_data"},  g.d, e.d);
      chk({tag, "_keep"},  64'(g.k), 64'(e.k));
      chk({tag, "_first"}, 64'(g.f), 64'(e.f));
      chk({tag, "_last"},  64'(g.l), 64'(e.l));
      chk({tag, "_len"},   64'(g.n), 64'(e.n));
      chk({tag, "_lerr"},  64'(g.e), 64'(e.e));
    end
    exp_q.delete();
    got_q.delete();
    chk({tag, "_perr"}, 64'(perr_seen), 64'(perr_exp));
  endtask

  task automatic chk_all_zero(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(rvalid), 64'(0));
    chk({tag, "_data"},  rdata, 64'(0));
    chk({tag, "_keep"},  64'(rkeep), 64'(0));
    chk({tag, "_first"}, 64'(rfirst), 64'(0));
    chk({tag, "_last"},  64'(rlast), 64'(0));
    chk({tag, "_len"},   64'(rlen), 64'(0));
    chk({tag, "_perr"},  64'(perr), 64'(0));
    chk({tag, "_lerr"},  64'(lerr), 64'(0));
  endtask

  function automatic logic [3:0] kmask(int nk);
    logic [3:0] m;
    m = 4'hF;
    return m << (4 - nk);
  endfunction

  initial begin
    // Reset state
    repeat (3) tick();
    chk_all_zero("reset");
    chk("reset_ready", 64'(ready_out), 64'(1));
    reset = 1'b0;
    tick();

    // Four full beats into two words
    send_beat(32'h11111111, 4'hF, 1, 0, 16'd16);
    send_beat(32'h22222222, 4'hF, 0, 0, 16'd0);
    send_beat(32'h33333333, 4'hF, 0, 0, 16'd0);
    send_beat(32'h44444444, 4'hF, 0, 1, 16'd0);
    chk("t1_model_w0", exp_q[0].d, 64'h1111111122222222);
    check_words("t1");

    // Three beats, partial keep on the last
    send_beat(32'hA0A0A0A0, 4'hF, 1, 0, 16'd10);
    send_beat(32'hB1B1B1B1, 4'hF, 0, 0, 16'd0);
    send_beat(32'hC2C2C2C2, 4'hC, 0, 1, 16'd0);
    chk("t2_model_keep", 64'(exp_q[1].k), 64'hC0);
    check_words("t2");

    // Backpressure holds the first word for five cycles
    ready_fix = 1'b0; rready = 1'b0;
    send_beat(32'h55550001, 4'hF, 1, 0, 16'd16);
    send_beat(32'h55550002, 4'hF, 0, 0, 16'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 64'(rvalid), 64'(1));
      chk("t3_hold_data", rdata, 64'h5555000155550002);
      chk("t3_hold_ready", 64'(ready_out), 64'(0));
      tick();
    end
    ready_fix = 1'b1; rready = 1'b1;
    send_beat(32'h55550003, 4'hF, 0, 0, 16'd0);
    send_beat(32'h55550004, 4'hF, 0, 1, 16'd0);
    check_words("t3");

    // Restart inside a packet
    send_beat(32'hDEAD0001, 4'hF, 1, 0, 16'd8);
    send_beat(32'hBEEF0001, 4'hF, 1, 0, 16'd8);
    send_beat(32'hBEEF0002, 4'hF, 0, 1, 16'd0);
    check_words("t4");

    // Stray beat in IDLE
    send_beat(32'h0BAD0BAD, 4'hF, 0, 1, 16'd4);
    check_words("t5");

    // Length mismatch: 20 claimed, 16 sent
    send_beat(32'h66666661, 4'hF, 1, 0, 16'd20);
    send_beat(32'h66666662, 4'hF, 0, 0, 16'd0);
    send_beat(32'h66666663, 4'hF, 0, 0, 16'd0);
    send_beat(32'h66666664, 4'hF, 0, 1, 16'd0);
    check_words("t6");

    // Randomized traffic with backpressure and framing faults
    bp_en = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int nb, nk, nbytes;
      logic [15:0] plen;
      nb = $urandom_range(1, 7);
      nk = $urandom_range(1, 4);
      nbytes = (nb - 1) * 4 + nk;
      plen = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 40)) : 16'(nbytes);
      if ($urandom_range(0, 9) == 0)
        send_beat($urandom, 4'hF, 0, 1'($urandom_range(0, 1)), 16'($urandom));
      for (int b = 0; b < nb; b++) begin
        bit lst, fst;
        lst = (b == nb - 1);
        fst = (b == 0) || ($urandom_range(0, 19) == 0);
        send_beat($urandom, lst ? kmask(nk) : 4'hF, fst, lst, fst ? plen : 16'($urandom));
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) tick();
      if (p % 8 == 7) check_words("rnd");
    end
    bp_en = 1'b0;
    check_words("rnd_end");

    // Reset while a word is held and a packet is open
    ready_fix = 1'b0; rready = 1'b0;
    send_beat(32'h77770001, 4'hF, 1, 0, 16'd12);
    send_beat(32'h77770002, 4'hF, 0, 0, 16'd0);
    reset = 1'b1;
    exp_q.delete();
    pd.delete(); pk.delete();
    m_in = 1'b0;
    tick();
    chk_all_zero("rst_mid");
    reset = 1'b0;
    ready_fix = 1'b1; rready = 1'b1;
    tick();
    send_beat(32'h77770003, 4'hF, 0, 1, 16'd0);
    check_words("rst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "bench time limit reached");
  end

endmodule
